// File: rtl/param_fancy_timer.sv
// Pattern-triggered delay timer: waits for a serial start pattern, shifts in a
// delay field, counts (delay+1)*TICK_CYCLES cycles, then holds done until ack.
module param_fancy_timer #(
  parameter int                 PAT_W       = 4,
  parameter logic [PAT_W-1:0]   PATTERN     = 4'b1101,
  parameter int                 DELAY_W     = 4,
  parameter int                 TICK_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data,
  input  logic               ack,
  output logic               shift_ena,
  output logic               counting,
  output logic               done,
  output logic [DELAY_W-1:0] count
);

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int BIT_W  = (DELAY_W > 1) ? $clog2(DELAY_W) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DELAY_W - 1);

  typedef enum logic [3:0] {
    SEARCH = 4'b0001,
    SHIFT  = 4'b0010,
    COUNT  = 4'b0100,
    WAIT   = 4'b1000
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [PAT_W-2:0]     history;
  logic [DELAY_W-1:0]   delay;
  logic [DELAY_W-1:0]   delay_shifted;
  logic [DELAY_W-1:0]   count_r;
  logic [TICK_W-1:0]    tick;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 match;
  logic                 tick_wrap;
  logic                 shift_last;

  // Size casts drop the bit shifted out of the top, so DELAY_W=1 / PAT_W=2 need no special case.
  assign delay_shifted = DELAY_W'({delay, data});
  assign match         = ({history, data} == PATTERN);
  assign tick_wrap     = (tick == TICK_LAST);
  assign shift_last    = (bit_cnt == BIT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEARCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      SEARCH: state_next = match ? SHIFT : SEARCH;
      SHIFT:  state_next = shift_last ? COUNT : SHIFT;
      COUNT:  state_next = (tick_wrap && (count_r == {DELAY_W{1'b0}})) ? WAIT : COUNT;
      WAIT:   state_next = ack ? SEARCH : WAIT;
      default: state_next = SEARCH;
    endcase
  end

  // Datapath: pattern history, delay shifter, tick prescaler and unit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      history <= {(PAT_W-1){1'b0}};
      delay   <= {DELAY_W{1'b0}};
      count_r <= {DELAY_W{1'b0}};
      tick    <= {TICK_W{1'b0}};
      bit_cnt <= {BIT_W{1'b0}};
    end else begin
      case (state)
        SEARCH: begin
          history <= (PAT_W-1)'({history, data});
          count_r <= {DELAY_W{1'b0}};
          tick    <= {TICK_W{1'b0}};
          bit_cnt <= {BIT_W{1'b0}};
        end
        SHIFT: begin
          delay   <= delay_shifted;
          bit_cnt <= bit_cnt + 1'b1;
          // The last delay bit arrives on the same edge that enters COUNT.
          if (shift_last) begin
            count_r <= delay_shifted;
          end else begin
            count_r <= {DELAY_W{1'b0}};
          end
        end
        COUNT: begin
          if (tick_wrap) begin
            tick <= {TICK_W{1'b0}};
            if (count_r != {DELAY_W{1'b0}}) begin
              count_r <= count_r - 1'b1;
            end else begin
              count_r <= count_r;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        WAIT: begin
          if (ack) begin
            history <= {(PAT_W-1){1'b0}};
          end else begin
            history <= history;
          end
        end
        default: begin
          history <= {(PAT_W-1){1'b0}};
          delay   <= {DELAY_W{1'b0}};
          count_r <= {DELAY_W{1'b0}};
          tick    <= {TICK_W{1'b0}};
          bit_cnt <= {BIT_W{1'b0}};
        end
      endcase
    end
  end

  assign shift_ena = (state == SHIFT);
  assign counting  = (state == COUNT);
  assign done      = (state == WAIT);
  assign count     = (state == COUNT) ? count_r : {DELAY_W{1'b0}};

endmodule

// File: tb/tb_param_fancy_timer.sv
// Bench for param_fancy_timer: a default instance plus an 8-bit, 1-cycle-tick
// instance, checked through a per-cycle expectation queue.
module tb_param_fancy_timer;

  localparam logic LO = 1'b0;
  localparam logic HI = 1'b1;

  logic       clk = 1'b0;
  logic       reset, data, ack;
  logic       shift_ena, counting, done;
  logic [3:0] count;
  logic       reset8, data8, ack8;
  logic       shift_ena8, counting8, done8;
  logic [7:0] count8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  param_fancy_timer dut (
    .clk(clk), .reset(reset), .data(data), .ack(ack),
    .shift_ena(shift_ena), .counting(counting), .done(done), .count(count)
  );

  param_fancy_timer #(.PAT_W(3), .PATTERN(3'b101), .DELAY_W(8), .TICK_CYCLES(1)) dut8 (
    .clk(clk), .reset(reset8), .data(data8), .ack(ack8),
    .shift_ena(shift_ena8), .counting(counting8), .done(done8), .count(count8)
  );

  typedef struct packed {
    logic       r, d, a;
    logic       s, c, dn;
    logic [7:0] cnt;
  } vec_t;

  typedef struct packed {
    logic       s, c, dn;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  function automatic vec_t v(logic r, logic d, logic a, logic s, logic c, logic dn, logic [7:0] cnt);
    vec_t x;
    x.r = r; x.d = d; x.a = a; x.s = s; x.c = c; x.dn = dn; x.cnt = cnt;
    return x;
  endfunction

  // Drive one cycle on the selected instance, queue its expectation, compare after the edge.
  task automatic cyc(input logic which, input logic r, input logic d, input logic a,
                     input logic s, input logic c, input logic dn, input logic [7:0] cnt,
                     input string tag);
    exp_t e;
    exp_t got;
    e.s = s; e.c = c; e.dn = dn; e.cnt = cnt;
    sb.push_back(e);
    if (which) begin
      reset8 = r; data8 = d; ack8 = a;
    end else begin
      reset = r; data = d; ack = a;
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (which) begin
      got.s = shift_ena8; got.c = counting8; got.dn = done8; got.cnt = count8;
    end else begin
      got.s = shift_ena; got.c = counting; got.dn = done; got.cnt = {4'b0000, count};
    end
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: got shift_ena=%b counting=%b done=%b count=%0d, expected shift_ena=%b counting=%b done=%b count=%0d",
               tag, $time, got.s, got.c, got.dn, got.cnt, e.s, e.c, e.dn, e.cnt);
    end
  endtask

  initial begin
    reset  = HI; data  = LO; ack  = LO;
    reset8 = HI; data8 = LO; ack8 = LO;

    // reset, ack ignored in SEARCH/SHIFT, reset mid-SHIFT, then 1101 + delay 0101
    tbl.push_back(v(HI, HI, HI, LO, LO, LO, 8'd0));
    tbl.push_back(v(HI, LO, LO, LO, LO, LO, 8'd0));
    tbl.push_back(v(LO, HI, HI, LO, LO, LO, 8'd0));
    tbl.push_back(v(LO, HI, LO, LO, LO, LO, 8'd0));
    tbl.push_back(v(LO, LO, LO, LO, LO, LO, 8'd0));
    tbl.push_back(v(LO, HI, LO, HI, LO, LO, 8'd0));
    tbl.push_back(v(LO, HI, HI, HI, LO, LO, 8'd0));
    tbl.push_back(v(LO, LO, LO, HI, LO, LO, 8'd0));
    tbl.push_back(v(HI, HI, LO, LO, LO, LO, 8'd0));
    tbl.push_back(v(LO, HI, LO, LO, LO, LO, 8'd0));
    tbl.push_back(v(LO, HI, LO, LO, LO, LO, 8'd0));
    tbl.push_back(v(LO, LO, LO, LO, LO, LO, 8'd0));
    tbl.push_back(v(LO, HI, LO, HI, LO, LO, 8'd0));
    tbl.push_back(v(LO, LO, HI, HI, LO, LO, 8'd0));
    tbl.push_back(v(LO, HI, LO, HI, LO, LO, 8'd0));
    tbl.push_back(v(LO, LO, LO, HI, LO, LO, 8'd0));
    tbl.push_back(v(LO, HI, LO, LO, HI, LO, 8'd5));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(LO, tbl[i].r, tbl[i].d, tbl[i].a, tbl[i].s, tbl[i].c, tbl[i].dn, tbl[i].cnt,
          $sformatf("table[%0d]", i));
    end

    // delay 5: 6000 counting cycles, 1000 per unit; data and ack are noise here
    for (int k = 1; k < 6000; k++) begin
      cyc(LO, LO, 1'($urandom), 1'($urandom), LO, HI, LO, 8'(5 - k / 1000), "count5");
    end
    cyc(LO, LO, 1'($urandom), 1'($urandom), LO, LO, HI, 8'd0, "enter_wait5");

    // data in WAIT and on the ack edge must not seed the next match
    cyc(LO, LO, HI, LO, LO, LO, HI, 8'd0, "wait_hold_a");
    cyc(LO, LO, HI, LO, LO, LO, HI, 8'd0, "wait_hold_b");
    cyc(LO, LO, LO, HI, LO, LO, LO, 8'd0, "ack_release");
    cyc(LO, LO, HI, LO, LO, LO, LO, 8'd0, "no_stale_match");
    cyc(LO, LO, HI, LO, LO, LO, LO, 8'd0, "search_b");
    cyc(LO, LO, LO, LO, LO, LO, LO, 8'd0, "search_c");
    cyc(LO, LO, HI, LO, HI, LO, LO, 8'd0, "fresh_match");

    // delay 0000 with ack held high through SHIFT and COUNT
    cyc(LO, LO, LO, HI, HI, LO, LO, 8'd0, "shift0_a");
    cyc(LO, LO, LO, HI, HI, LO, LO, 8'd0, "shift0_b");
    cyc(LO, LO, LO, HI, HI, LO, LO, 8'd0, "shift0_c");
    cyc(LO, LO, LO, HI, LO, HI, LO, 8'd0, "enter_count0");
    for (int k = 1; k < 1000; k++) begin
      cyc(LO, LO, 1'($urandom), HI, LO, HI, LO, 8'd0, "count0");
    end
    cyc(LO, LO, LO, HI, LO, LO, HI, 8'd0, "enter_wait0");
    cyc(LO, LO, LO, LO, LO, LO, HI, 8'd0, "wait0_a");
    cyc(LO, LO, LO, LO, LO, LO, HI, 8'd0, "wait0_b");
    cyc(LO, LO, LO, HI, LO, LO, LO, 8'd0, "ack0");

    // overlapping match 1,1,1,0,1 then delay 0011, reset at COUNT cycle 2500
    cyc(LO, LO, HI, LO, LO, LO, LO, 8'd0, "ovl_1");
    cyc(LO, LO, HI, LO, LO, LO, LO, 8'd0, "ovl_2");
    cyc(LO, LO, HI, LO, LO, LO, LO, 8'd0, "ovl_3");
    cyc(LO, LO, LO, LO, LO, LO, LO, 8'd0, "ovl_4");
    cyc(LO, LO, HI, LO, HI, LO, LO, 8'd0, "ovl_match");
    cyc(LO, LO, LO, LO, HI, LO, LO, 8'd0, "shift3_a");
    cyc(LO, LO, LO, LO, HI, LO, LO, 8'd0, "shift3_b");
    cyc(LO, LO, HI, LO, HI, LO, LO, 8'd0, "shift3_c");
    cyc(LO, LO, HI, LO, LO, HI, LO, 8'd3, "enter_count3");
    for (int k = 1; k < 2500; k++) begin
      cyc(LO, LO, 1'($urandom), 1'($urandom), LO, HI, LO, 8'(3 - k / 1000), "count3");
    end
    cyc(LO, HI, HI, HI, LO, LO, LO, 8'd0, "reset_mid_count");
    cyc(LO, HI, HI, LO, LO, LO, LO, 8'd0, "reset_hold");

    // restart after reset: 1101, delay 0001
    cyc(LO, LO, HI, LO, LO, LO, LO, 8'd0, "rs_1");
    cyc(LO, LO, HI, LO, LO, LO, LO, 8'd0, "rs_2");
    cyc(LO, LO, LO, LO, LO, LO, LO, 8'd0, "rs_3");
    cyc(LO, LO, HI, LO, HI, LO, LO, 8'd0, "rs_match");
    cyc(LO, LO, LO, LO, HI, LO, LO, 8'd0, "shift1_a");
    cyc(LO, LO, LO, LO, HI, LO, LO, 8'd0, "shift1_b");
    cyc(LO, LO, LO, LO, HI, LO, LO, 8'd0, "shift1_c");
    cyc(LO, LO, HI, LO, LO, HI, LO, 8'd1, "enter_count1");
    for (int k = 1; k < 2000; k++) begin
      cyc(LO, LO, 1'($urandom), 1'($urandom), LO, HI, LO, 8'(1 - k / 1000), "count1");
    end
    cyc(LO, LO, LO, LO, LO, LO, HI, 8'd0, "enter_wait1");
    cyc(LO, LO, LO, HI, LO, LO, LO, 8'd0, "ack1");
    reset = HI;

    // 8-bit delay, one-cycle tick, pattern 101, delay FF
    cyc(HI, HI, HI, LO, LO, LO, LO, 8'd0, "w8_reset");
    cyc(HI, LO, HI, LO, LO, LO, LO, 8'd0, "w8_p1");
    cyc(HI, LO, LO, LO, LO, LO, LO, 8'd0, "w8_p2");
    cyc(HI, LO, HI, LO, HI, LO, LO, 8'd0, "w8_match");
    for (int k = 0; k < 7; k++) begin
      cyc(HI, LO, HI, LO, HI, LO, LO, 8'd0, "w8_shift");
    end
    cyc(HI, LO, HI, LO, LO, HI, LO, 8'd255, "w8_enter_count");
    for (int k = 1; k < 256; k++) begin
      cyc(HI, LO, 1'($urandom), 1'($urandom), LO, HI, LO, 8'(255 - k), "w8_count");
    end
    cyc(HI, LO, LO, LO, LO, LO, HI, 8'd0, "w8_enter_wait");
    cyc(HI, LO, LO, LO, LO, LO, HI, 8'd0, "w8_wait");
    cyc(HI, LO, LO, HI, LO, LO, LO, 8'd0, "w8_ack");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_fancy_timer.md
PARAM_FANCY_TIMER -- requirements
Module: param_fancy_timer

Interface
REQ-001 Parameter PAT_W, default 4: length of the start pattern in bits; legal values are 2 or more.
REQ-002 Parameter PATTERN, default 4'b1101: start pattern, PAT_W bits wide, matched MSB first.
REQ-003 Parameter DELAY_W, default 4: width of the serially loaded delay field; legal values are 1 or more.
REQ-004 Parameter TICK_CYCLES, default 1000: clock cycles per delay unit; legal values are 1 or more.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port data, input, 1 bit: serial input, sampled every rising edge.
REQ-008 Port ack, input, 1 bit: user acknowledge of timer expiry.
REQ-009 Port shift_ena, output, 1 bit: high while the delay field is being shifted in.
REQ-010 Port counting, output, 1 bit: high while the timer is running.
REQ-011 Port done, output, 1 bit: high while the timer has expired and is awaiting ack.
REQ-012 Port count, output, DELAY_W bits: remaining whole delay units while counting; 0 otherwise.

Function
REQ-013 The FSM SHALL have four one-hot states: SEARCH, SHIFT, COUNT, WAIT; all outputs are Moore, decoded from registered state only.
REQ-014 SEARCH: keep a PAT_W-1 bit history of data; on an edge where {history, data} == PATTERN, go to SHIFT (overlapping matches are allowed).
REQ-015 SHIFT: shift_ena=1 for exactly DELAY_W cycles; each edge shifts data MSB-first into the delay register (delay <= {delay[DELAY_W-2:0], data}); after the DELAY_W-th bit, go to COUNT.
REQ-016 COUNT: counting=1, and count is loaded from delay on entry.
REQ-017 COUNT: the tick counter (width clog2(TICK_CYCLES), minimum 1) SHALL run 0..TICK_CYCLES-1; on wrap, count decrements by 1.
REQ-018 COUNT SHALL last exactly (delay+1)*TICK_CYCLES cycles; at tick==TICK_CYCLES-1 with count==0, go to WAIT.
REQ-019 When TICK_CYCLES=1, each delay unit SHALL be one cycle; no divide-by-zero and no zero-width counter.
REQ-020 WAIT: done=1; on an edge with ack=1, go to SEARCH with history cleared; data is ignored in WAIT.
REQ-021 ack SHALL be ignored in SEARCH, SHIFT and COUNT; data SHALL be ignored in COUNT and WAIT.
REQ-022 Pattern bits arriving on the same edge as the ack that leaves WAIT SHALL NOT count toward a match.
REQ-023 count SHALL read 0 in SEARCH, SHIFT and WAIT.
REQ-024 At most one of shift_ena, counting and done SHALL be high in any cycle.

Reset
REQ-025 reset=1 at an edge SHALL take priority over all other inputs and force: state SEARCH, history 0, delay 0, tick 0, count 0.
REQ-026 While reset is high, shift_ena, counting and done SHALL all be 0.
REQ-027 Reset asserted mid-SHIFT, mid-COUNT or in WAIT SHALL abort the operation; outputs read 0 from the next cycle.
REQ-028 No state outside the four legal states SHALL be reachable after reset.

Verification (defaults unless stated)
REQ-029 Reset, then data 1,1,0,1,0,1,0,1 -> shift_ena=1 for the 4 cycles after the 4th bit; then counting=1 for exactly 6000 cycles with count=5,4,3,2,1,0 for 1000 cycles each; then done=1 until ack.
REQ-030 Overlap: data 1,1,1,0,1 -> match on the 5th bit; shift_ena rises the following cycle.
REQ-031 Delay field 0000 -> counting=1 for exactly 1000 cycles with count=0 throughout; then done=1.
REQ-032 ack held high through SHIFT and COUNT has no effect; in WAIT, a 1-cycle ack -> done=0 next cycle; a fresh 1101 is required to restart.
REQ-033 reset pulsed at cycle 2500 of COUNT -> next cycle counting=0, count=0, state SEARCH; a subsequent 1101 restarts normally.
REQ-034 Instance with DELAY_W=8, TICK_CYCLES=1, PATTERN=3'b101, PAT_W=3: delay 8'hFF -> counting=1 for exactly 256 cycles, with count decrementing every cycle.
